// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes and sequencer states.
package mips_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift/add multiply and restoring divide datapath with sign fix-up and hi/lo result registers.
// Divide hardware is present only when MULDIV_DIV_EN is defined.
module muldiv_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             write,
   input  logic             is_signed,
`ifdef MULDIV_DIV_EN
   input  logic             is_div,
   output logic             div_zero,
`endif
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   q_q;
   logic [WIDTH-1:0]   b_q;
   logic               neg_lo_q;
   logic               rs_neg;
   logic               rt_neg;
   logic [WIDTH-1:0]   rs_mag;
   logic [WIDTH-1:0]   rt_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] fix_prod;

   assign rs_neg   = is_signed & rs_val[WIDTH-1];
   assign rt_neg   = is_signed & rt_val[WIDTH-1];
   assign rs_mag   = rs_neg ? -rs_val : rs_val;
   assign rt_mag   = rt_neg ? -rt_val : rt_val;
   assign mul_sum  = {1'b0, a_q} + (q_q[0] ? {1'b0, b_q} : '0);
   assign product  = {a_q, q_q};
   assign fix_prod = neg_lo_q ? -product : product;

`ifdef MULDIV_DIV_EN
   logic             div_q;
   logic             neg_hi_q;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   assign div_zero  = (rt_val == '0);
   assign div_shift = {a_q, q_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         q_q      <= '0;
         b_q      <= '0;
         neg_lo_q <= 1'b0;
         hi       <= '0;
         lo       <= '0;
`ifdef MULDIV_DIV_EN
         div_q    <= 1'b0;
         neg_hi_q <= 1'b0;
`endif
      end else begin
         if (load) begin
            a_q      <= '0;
            q_q      <= rt_mag;
            b_q      <= rs_mag;
            neg_lo_q <= rs_neg ^ rt_neg;
`ifdef MULDIV_DIV_EN
            div_q    <= is_div;
            neg_hi_q <= rs_neg;
            if (is_div) begin
               q_q <= rs_mag;
               b_q <= rt_mag;
               // Zero divisor: preload the fixed result so FIX just copies it out
               if (div_zero) begin
                  a_q      <= rs_val;
                  q_q      <= '1;
                  neg_lo_q <= 1'b0;
                  neg_hi_q <= 1'b0;
               end
            end
`endif
         end else if (step) begin
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               a_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
               q_q <= {q_q[WIDTH-2:0], div_ge};
            end else
`endif
            begin
               a_q <= mul_sum[WIDTH:1];
               q_q <= {mul_sum[0], q_q[WIDTH-1:1]};
            end
         end

         if (write) begin
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               lo <= neg_lo_q ? -q_q : q_q;
               hi <= neg_hi_q ? -a_q : a_q;
            end else
`endif
            begin
               {hi, lo} <= fix_prod;
            end
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: FSM, iteration counter and pipeline stall.
// Define MULDIV_DIV_EN to include the divide path; otherwise divide requests are ignored.
module muldiv_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e        state;
   state_e        state_next;
   op_e           op_kind;
   logic [CW-1:0] count;
   logic          is_signed;
   logic          op_ok;
   logic          load;
   logic          step;
   logic          write;

   assign op_kind   = op_e'(op);
   assign is_signed = (op_kind == OP_MULT) || (op_kind == OP_DIV);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

`ifdef MULDIV_DIV_EN
   logic div_req;
   logic rt_zero;
   logic dz_q;

   assign op_ok       = 1'b1;
   assign div_req     = (op_kind == OP_DIV) || (op_kind == OP_DIVU);
   assign div_by_zero = done & dz_q;
`else
   assign op_ok       = (op_kind == OP_MULT) || (op_kind == OP_MULTU);
   assign div_by_zero = 1'b0;
`endif

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      write      = 1'b0;
      stall      = 1'b0;
      case (state)
         S_IDLE: begin
            stall = start & op_ok;
            if (start && op_ok && !flush) begin
               load       = 1'b1;
`ifdef MULDIV_DIV_EN
               state_next = (div_req && rt_zero) ? S_FIX : S_CALC;
`else
               state_next = S_CALC;
`endif
            end
         end
         S_CALC: begin
            stall = 1'b1;
            step  = 1'b1;
            if (count == LAST) state_next = S_FIX;
         end
         S_FIX: begin
            stall      = 1'b1;
            write      = 1'b1;
            state_next = S_DONE;
         end
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      // Flush aborts in any state, suppressing any register update this cycle
      if (flush) begin
         state_next = S_IDLE;
         load       = 1'b0;
         step       = 1'b0;
         write      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         if (load)      count <= '0;
         else if (step) count <= count + 1'b1;
      end
   end

`ifdef MULDIV_DIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    dz_q <= 1'b0;
      else if (load) dz_q <= div_req & rt_zero;
   end
`endif

   muldiv_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .write     (write),
      .is_signed (is_signed),
`ifdef MULDIV_DIV_EN
      .is_div    (div_req),
      .div_zero  (rt_zero),
`endif
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .hi        (hi),
      .lo        (lo)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32); divide cases follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic         flush;
   logic         stall;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .flush       (flush),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for one cycle (cycle T); returns with the bench in cycle T+1.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic stall_t);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      stall_t = stall;
      next_cycle();
      start = 1'b0;
   endtask

   // Counts cycles after T until done; returns at the negedge of the done cycle.
   task automatic wait_done(output int lat, output logic stall_good);
      bit found = 0;
      lat = 1;
      stall_good = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (stall !== ~done) stall_good = 1'b0;
         if (done === 1'b1) begin
            found = 1;
            break;
         end
         next_cycle();
         lat++;
      end
      if (!found) lat = -1;
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                      input logic [31:0] exp_lo, input logic exp_dz);
      logic st;
      logic sg;
      int   lat;
      next_cycle();
      issue(o, a, b, st);
      wait_done(lat, sg);
      chk($sformatf("%s latency", tag), lat, exp_lat);
      chk($sformatf("%s stall@T", tag), {31'd0, st}, 32'd1);
      chk($sformatf("%s stall window", tag), {31'd0, sg}, 32'd1);
      chk($sformatf("%s hi", tag), hi, exp_hi);
      chk($sformatf("%s lo", tag), lo, exp_lo);
      chk($sformatf("%s div_by_zero", tag), {31'd0, div_by_zero}, {31'd0, exp_dz});
      next_cycle();
      @(negedge clk);
      chk($sformatf("%s busy after", tag), {31'd0, busy}, 32'd0);
      chk($sformatf("%s done pulse", tag), {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic st;
      logic sg;
      logic seen;
      int   lat;
      logic [1:0] rst_op;

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      #2;
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset dz", {31'd0, div_by_zero}, 32'd0);
      #10 rst_n = 1'b1;

      run("mult -2*3",   2'b00, 32'hFFFFFFFE, 32'd3,        34, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run("multu max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run("mult 7*-5",   2'b00, 32'd7,        32'hFFFFFFFB, 34, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0);
      run("mult min*min",2'b00, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 1'b0);

      // flush at T+10 of a MULT, then a fresh MULT at T+12
      next_cycle();
      issue(2'b00, 32'd9, 32'd9, st);
      repeat (9) next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("flush busy", {31'd0, busy}, 32'd0);
      chk("flush done", {31'd0, done}, 32'd0);
      chk("flush hi kept", hi, 32'h40000000);
      chk("flush lo kept", lo, 32'h00000000);
      next_cycle();
      issue(2'b00, 32'd3, 32'd4, st);
      wait_done(lat, sg);
      chk("post-flush latency", lat, 34);
      chk("post-flush lo", lo, 32'd12);
      chk("post-flush hi", hi, 32'd0);

      // flush beats a simultaneous start
      next_cycle();
      next_cycle();
      start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd2; flush = 1'b1;
      next_cycle();
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush+start busy", {31'd0, busy}, 32'd0);

`ifdef MULDIV_DIV_EN
      run("div -7/2",    2'b10, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run("div 7/-2",    2'b10, 32'd7,        32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run("divu 100/7",  2'b11, 32'd100,      32'd7,        34, 32'd2,        32'd14,       1'b0);
      run("div min/-1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0);
      run("div 5/0",     2'b10, 32'd5,        32'd0,        2,  32'd5,        32'hFFFFFFFF, 1'b1);
      rst_op = 2'b11;
`else
      // divide request with no divide hardware: nothing happens
      next_cycle();
      start = 1'b1; op = 2'b10; rs_val = 32'd5; rt_val = 32'd0;
      @(negedge clk);
      chk("nodiv stall@T", {31'd0, stall}, 32'd0);
      next_cycle();
      start = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (stall || busy || done) seen = 1'b1;
         next_cycle();
      end
      chk("nodiv activity", {31'd0, seen}, 32'd0);
      chk("nodiv hi kept", hi, 32'd0);
      chk("nodiv lo kept", lo, 32'd12);
      rst_op = 2'b01;
`endif

      // asynchronous reset at T+5 of an operation
      next_cycle();
      issue(rst_op, 32'd100, 32'd7, st);
      repeat (4) next_cycle();
      rst_n = 1'b0;
      #1;
      chk("midreset hi", hi, 32'h0);
      chk("midreset lo", lo, 32'h0);
      chk("midreset busy", {31'd0, busy}, 32'd0);
      chk("midreset stall", {31'd0, stall}, 32'd0);
      chk("midreset done", {31'd0, done}, 32'd0);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("midreset no done", {31'd0, seen}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand width and iteration count.
REQ-002 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation from the EX stage.
REQ-005 op  input  2  SHALL select 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_val  input  WIDTH  SHALL carry the multiplicand or dividend.
REQ-007 rt_val  input  WIDTH  SHALL carry the multiplier or divisor.
REQ-008 flush  input  1  SHALL abort any operation in flight.
REQ-009 stall  output  1  SHALL freeze the IF/ID/EX pipeline latches while high.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 done  output  1  SHALL pulse for one cycle when hi/lo are updated.
REQ-012 hi, lo  output  WIDTH each  SHALL hold the upper product or remainder, and the lower product or quotient.
REQ-013 div_by_zero  output  1  SHALL be high with done when the divisor was zero.

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE.
REQ-015 IDLE->CALC on start: latch op, operand magnitudes (signed ops), result signs; count=0.
REQ-016 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; count+1; ->FIX when count==WIDTH-1.
REQ-017 FIX: negate product/quotient/remainder as required; write hi/lo; ->DONE.
REQ-018 DONE: done=1 for one cycle; ->IDLE.
REQ-019 Latency: start accepted at cycle T -> done at T+WIDTH+2; hi/lo valid from that cycle.
REQ-020 stall = (IDLE & start) | CALC | FIX; low in DONE so the consumer advances.
REQ-021 start outside IDLE SHALL be ignored; a start coinciding with DONE waits until IDLE.
REQ-022 Signed multiply: hi:lo = 2*WIDTH-bit two's-complement product; unsigned: zero-extended product.
REQ-023 Signed divide: quotient truncates toward zero; remainder takes the dividend's sign; -2^(WIDTH-1)/-1 gives lo=0x80000000, hi=0.
REQ-024 Divide by zero: IDLE->FIX directly (CALC skipped); hi=rs_val, lo=all ones, div_by_zero=1; done at T+2.
REQ-025 flush in any state: ->IDLE next cycle, hi/lo unchanged, no done; flush wins over a simultaneous start.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, count=0, hi=0, lo=0, done=0, div_by_zero=0, busy=0.
REQ-027 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-028 With MULDIV_DIV_EN defined, DIV/DIVU SHALL be implemented per REQ-016..024.
REQ-029 Without MULDIV_DIV_EN, divide hardware SHALL be absent; start with op[1]=1 ignored (no stall, no done, hi/lo unchanged).

Structure
REQ-030 Shared package mips_pkg SHALL hold the op encodings and FSM state encodings.
REQ-031 Sub-module muldiv_datapath SHALL hold the shift registers, adder/subtractor and sign fix-up; the FSM and counter SHALL stay in muldiv_sequencer.

Verification
REQ-032 MULT rs=0xFFFFFFFE(-2), rt=3 -> done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; stall high T..T+33.
REQ-034 DIV rs=-7, rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU rs=100, rt=7 -> lo=14, hi=2.
REQ-035 DIV rs=5, rt=0 -> done at T+2, div_by_zero=1, hi=5, lo=0xFFFFFFFF.
REQ-036 flush at T+10 of MULT -> busy low at T+11, no done, hi/lo keep prior values; second start at T+12 completes normally.
REQ-037 rst_n low at T+5 of DIVU -> all outputs zero immediately; build without MULDIV_DIV_EN: DIV start -> stall never asserts.
